uart_receiver_param: RTL and testbench
======================================

// Module: uart_receiver_param
// PURPOSE
//  Parametrised successor to the 8-bit UART receiver. Oversampled serial RX with configurable
//  word size, sample rate, optional parity and 1/2 stop bits. Received words go into a small
//  FIFO so the host can read them late without losing data. Overrun, framing and parity errors
//  are flagged separately. Sits between the pad-level Serial_in line and the host read port.
// PARAMETERS
//  WORD_SIZE    8  data bits per frame, LSB first (5..16)
//  OVERSAMPLE   8  Sample_clk cycles per bit; even, >=4
//  PARITY_EN    0  1 = parity bit follows the data bits
//  PARITY_ODD   0  0 = even parity, 1 = odd (ignored when PARITY_EN=0)
//  STOP_BITS    1  stop bits checked: 1 or 2
//  FIFO_DEPTH   4  receive FIFO entries; power of 2, >=2
// PORTS
//  Sample_clk   in   1                  oversampling clock; all logic on rising edge
//  rst_b        in   1                  synchronous, active-low reset
//  Serial_in    in   1                  asynchronous RX line; idle high
//  rd_en        in   1                  pop FIFO head this cycle; ignored when data_valid=0
//  clr_err      in   1                  clears all sticky error flags
//  RCV_datareg  out  WORD_SIZE          FIFO head word; valid when data_valid=1
//  data_valid   out  1                  FIFO non-empty
//  fifo_count   out  $clog2(FIFO_DEPTH+1)  words held
//  Error1       out  1                  sticky overrun: word dropped because FIFO full
//  Error2       out  1                  sticky framing: a stop bit sampled 0
//  Error3       out  1                  sticky parity mismatch (stays 0 when PARITY_EN=0)
//  busy         out  1                  frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (rst_b=0 at an edge): all outputs 0, RCV_datareg=0, FIFO emptied, state IDLE,
//    synchroniser flops set to 1, armed=0. A partial frame is discarded.
//  - Serial_in passes a 2-flop synchroniser; all references below are to the synced value.
//  - armed sets once synced line is seen 1 in IDLE; a start is only accepted while armed
//    (a line held low through reset release is never taken as a start bit).
//  - FSM IDLE->START->DATA->[PARITY]->STOP->IDLE. Sample counter SC, bit counter BC.
//    IDLE: synced line 0 and armed -> START, SC=0.
//    START: at SC=OVERSAMPLE/2-1 sample: 1 -> IDLE (false start, no flag); 0 -> DATA, SC=0, BC=0.
//    DATA: sample when SC=OVERSAMPLE-1 (mid-bit), shift right into shift reg, BC++;
//      BC reaches WORD_SIZE -> PARITY if PARITY_EN else STOP.
//    PARITY: sample at SC=OVERSAMPLE-1; mismatch recorded for this frame.
//    STOP: sample each stop bit at SC=OVERSAMPLE-1; any 0 marks framing error.
//      After last stop sample -> IDLE on next edge (mid-stop), so back-to-back frames work.
//  - Frame completion (cycle after last stop sample): framing err -> Error2=1, word discarded;
//    else parity err -> Error3=1, word discarded; else push to FIFO.
//  - Push with FIFO full: if rd_en same cycle, pop and push both occur (count unchanged);
//    otherwise word dropped, Error1=1, FIFO contents untouched.
//  - Pop: rd_en=1 and data_valid=1 -> next head on RCV_datareg next cycle; empty pop is no-op.
//  - Push into empty FIFO: data_valid=1 and RCV_datareg=word the cycle after frame completion.
//  - Latency: Serial_in edge to FSM reaction = 2 cycles (synchroniser).
//  - clr_err with a new error same cycle: error wins (flag stays 1).
//  - Break (line held 0): one framing error per frame; no new start until line returns to 1.
// TESTING (OVERSAMPLE=8, clock period 10, bit time 80)
//  1 Idle 200, frame 0x55 8N1 -> data_valid=1, RCV_datareg=8'h55, fifo_count=1, errors 0.
//  2 Line low 30 (3 clks) then high -> back to IDLE from START, no word, no error.
//  3 Frame 0xC3 with stop bit 0 -> Error2=1, fifo_count unchanged; clr_err -> Error2=0.
//  4 Five frames 0x11..0x55, rd_en=0, FIFO_DEPTH=4 -> count=4, Error1=1, head=8'h11;
//    four pops -> 0x11,0x22,0x33,0x44 in order, data_valid=0.
//  5 PARITY_EN=1 even: 0xA3 with parity 0 -> accepted; with parity 1 -> Error3=1, discarded.
//  6 rst_b=0 for 2 clks mid-DATA -> count=0, busy=0; next frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_receiver_param.sv
// Oversampled UART receiver with configurable framing and a small receive FIFO.
// Sticky overrun/framing/parity flags; FIFO head is presented as a registered word.
module uart_receiver_param #(
  parameter int WORD_SIZE  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              Sample_clk,
  input  logic                              rst_b,
  input  logic                              Serial_in,
  input  logic                              rd_en,
  input  logic                              clr_err,
  output logic [WORD_SIZE-1:0]              RCV_datareg,
  output logic                              data_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              Error1,
  output logic                              Error2,
  output logic                              Error3,
  output logic                              busy
);

  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(WORD_SIZE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [SC_W-1:0]  SC_HALF  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  BC_WLAST = BC_W'(WORD_SIZE - 1);
  localparam logic [BC_W-1:0]  BC_SLAST = BC_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic             ODD_PAR  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic                 sync1_reg, sync2_reg;
  state_t               state_reg;
  logic [SC_W-1:0]      sc_reg;
  logic [BC_W-1:0]      bc_reg;
  logic [WORD_SIZE-1:0] shift_reg;
  logic                 armed_reg;
  logic                 frame_err_reg;
  logic                 par_err_reg;
  logic                 done_reg;
  logic                 line;

  always_ff @(posedge Sample_clk) begin
    if (!rst_b) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= Serial_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign line = sync2_reg;

  // Receive FSM; done_reg pulses for the single cycle after the last stop sample.
  always_ff @(posedge Sample_clk) begin
    if (!rst_b) begin
      state_reg     <= IDLE;
      sc_reg        <= '0;
      bc_reg        <= '0;
      shift_reg     <= '0;
      armed_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      par_err_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (line) begin
            armed_reg <= 1'b1;
          end else if (armed_reg) begin
            // Disarm so a stuck-low line yields only one frame.
            state_reg     <= START;
            sc_reg        <= '0;
            armed_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            par_err_reg   <= 1'b0;
          end
        end
        START: begin
          if (sc_reg == SC_HALF) begin
            sc_reg <= '0;
            bc_reg <= '0;
            state_reg <= line ? IDLE : DATA;
          end else begin
            sc_reg <= sc_reg + 1'b1;
          end
        end
        DATA: begin
          if (sc_reg == SC_LAST) begin
            sc_reg    <= '0;
            shift_reg <= {line, shift_reg[WORD_SIZE-1:1]};
            if (bc_reg == BC_WLAST) begin
              bc_reg    <= '0;
              state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bc_reg <= bc_reg + 1'b1;
            end
          end else begin
            sc_reg <= sc_reg + 1'b1;
          end
        end
        PARITY: begin
          if (sc_reg == SC_LAST) begin
            sc_reg      <= '0;
            par_err_reg <= ((^shift_reg) ^ line) != ODD_PAR;
            state_reg   <= STOP;
          end else begin
            sc_reg <= sc_reg + 1'b1;
          end
        end
        STOP: begin
          if (sc_reg == SC_LAST) begin
            sc_reg <= '0;
            if (!line) frame_err_reg <= 1'b1;
            if (bc_reg == BC_SLAST) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end else begin
              bc_reg <= bc_reg + 1'b1;
            end
          end else begin
            sc_reg <= sc_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next, remaining;
  logic [WORD_SIZE-1:0] head_reg, head_next;
  logic                 err1_reg, err2_reg, err3_reg;
  logic                 pop, push_req, push_ok, overrun;

  always_comb begin
    pop         = rd_en && (count_reg != '0);
    push_req    = done_reg && !frame_err_reg && !par_err_reg;
    push_ok     = push_req && ((count_reg != CNT_FULL) || pop);
    overrun     = push_req && (count_reg == CNT_FULL) && !pop;
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    remaining   = count_reg - CNT_W'(pop);
    count_next  = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
    head_next   = head_reg;
    // With nothing left behind the popped entry, the head can only come from the push.
    if (remaining == '0) begin
      if (push_ok) head_next = shift_reg;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge Sample_clk) begin
    if (push_ok) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge Sample_clk) begin
    if (!rst_b) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      err1_reg   <= 1'b0;
      err2_reg   <= 1'b0;
      err3_reg   <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      count_reg <= count_next;
      head_reg  <= head_next;
      err1_reg  <= (err1_reg & ~clr_err) | overrun;
      err2_reg  <= (err2_reg & ~clr_err) | (done_reg & frame_err_reg);
      err3_reg  <= (err3_reg & ~clr_err) | (done_reg & ~frame_err_reg & par_err_reg);
    end
  end

  assign RCV_datareg = head_reg;
  assign data_valid  = (count_reg != '0);
  assign fifo_count  = count_reg;
  assign Error1      = err1_reg;
  assign Error2      = err2_reg;
  assign Error3      = err3_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver_param.sv
// Bench for uart_receiver_param: 8N1 instance and an even-parity instance,
// directed plus randomized frames checked against a queue-based reference model.
module tb_uart_receiver_param;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       ser_a, ser_b, rd_a, rd_b, clr_a, clr_b;
  logic [7:0] dat_a, dat_b;
  logic [2:0] cnt_a, cnt_b;
  logic       dv_a, e1_a, e2_a, e3_a, busy_a;
  logic       dv_b, e1_b, e2_b, e3_b, busy_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  bit m1_a, m2_a, m3_a, m1_b, m2_b, m3_b;

  always #5 clk = ~clk;

  uart_receiver_param dut_a (
    .Sample_clk(clk), .rst_b(rst_b), .Serial_in(ser_a), .rd_en(rd_a), .clr_err(clr_a),
    .RCV_datareg(dat_a), .data_valid(dv_a), .fifo_count(cnt_a),
    .Error1(e1_a), .Error2(e2_a), .Error3(e3_a), .busy(busy_a)
  );

  uart_receiver_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .Sample_clk(clk), .rst_b(rst_b), .Serial_in(ser_b), .rd_en(rd_b), .clr_err(clr_b),
    .RCV_datareg(dat_b), .data_valid(dv_b), .fifo_count(cnt_b),
    .Error1(e1_b), .Error2(e2_b), .Error3(e3_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) ser_a = v;
    else ser_b = v;
  endtask

  // One frame at 8 clocks per bit; optional rd_en pulse timed onto the push cycle.
  task automatic send(input int sel, input logic [7:0] d, input bit has_par, input bit par_bit,
                      input bit stop_bit, input bit pop_at_end);
    drive(sel, 1'b0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      repeat (8) @(negedge clk);
    end
    if (has_par) begin
      drive(sel, par_bit);
      repeat (8) @(negedge clk);
    end
    drive(sel, stop_bit);
    repeat (7) @(negedge clk);
    if (pop_at_end) rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
    drive(sel, 1'b1);
    repeat (4) @(negedge clk);
    $display("frame dut%0d data=%02h par=%0d/%0d stop=%0d pop=%0d", sel, d, has_par, par_bit,
             stop_bit, pop_at_end);
  endtask

  task automatic model_a(input logic [7:0] d, input bit stop_ok, input bit pop);
    bit full;
    full = (q_a.size() == DEPTH);
    if (pop && q_a.size() > 0) void'(q_a.pop_front());
    if (!stop_ok) m2_a = 1'b1;
    else if (full && !pop) m1_a = 1'b1;
    else q_a.push_back(d);
  endtask

  task automatic model_b(input logic [7:0] d, input bit par_bit, input bit stop_ok);
    bit even_par;
    even_par = ($countones(d) % 2) != 0;
    if (!stop_ok) m2_b = 1'b1;
    else if (par_bit != even_par) m3_b = 1'b1;
    else if (q_b.size() == DEPTH) m1_b = 1'b1;
    else q_b.push_back(d);
  endtask

  task automatic check_a(input string tag);
    chk({tag, "/a_dv"}, dv_a, q_a.size() != 0);
    chk({tag, "/a_cnt"}, cnt_a, q_a.size());
    if (q_a.size() > 0) chk({tag, "/a_head"}, dat_a, q_a[0]);
    chk({tag, "/a_e1"}, e1_a, m1_a);
    chk({tag, "/a_e2"}, e2_a, m2_a);
    chk({tag, "/a_e3"}, e3_a, m3_a);
    chk({tag, "/a_busy"}, busy_a, 0);
  endtask

  task automatic check_b(input string tag);
    chk({tag, "/b_dv"}, dv_b, q_b.size() != 0);
    chk({tag, "/b_cnt"}, cnt_b, q_b.size());
    if (q_b.size() > 0) chk({tag, "/b_head"}, dat_b, q_b[0]);
    chk({tag, "/b_e1"}, e1_b, m1_b);
    chk({tag, "/b_e2"}, e2_b, m2_b);
    chk({tag, "/b_e3"}, e3_b, m3_b);
    chk({tag, "/b_busy"}, busy_b, 0);
  endtask

  task automatic pop_a();
    @(negedge clk) rd_a = 1'b1;
    @(negedge clk) rd_a = 1'b0;
    if (q_a.size() > 0) void'(q_a.pop_front());
  endtask

  task automatic pop_b();
    @(negedge clk) rd_b = 1'b1;
    @(negedge clk) rd_b = 1'b0;
    if (q_b.size() > 0) void'(q_b.pop_front());
  endtask

  task automatic clear_a();
    @(negedge clk) clr_a = 1'b1;
    @(negedge clk) clr_a = 1'b0;
    m1_a = 0; m2_a = 0; m3_a = 0;
  endtask

  task automatic clear_b();
    @(negedge clk) clr_b = 1'b1;
    @(negedge clk) clr_b = 1'b0;
    m1_b = 0; m2_b = 0; m3_b = 0;
  endtask

  initial begin
    logic [7:0] d;
    bit         ok, pb;
    rst_b = 1'b0; ser_a = 1'b1; ser_b = 1'b1;
    rd_a = 1'b0; rd_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset/a_head", dat_a, 0);
    check_a("reset");
    check_b("reset");
    rst_b = 1'b1;
    repeat (20) @(negedge clk);

    // Basic 8N1 reception
    send(0, 8'h55, 0, 0, 1, 0);
    model_a(8'h55, 1, 0);
    check_a("t1_0x55");

    // Short glitch is a false start
    ser_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_busy_in_start", busy_a, 1);
    ser_a = 1'b1;
    repeat (10) @(negedge clk);
    check_a("t2_false_start");

    // Framing error, then clear
    send(0, 8'hC3, 0, 0, 0, 0);
    model_a(8'hC3, 0, 0);
    check_a("t3_framing");
    clear_a();
    check_a("t3_cleared");
    pop_a();
    check_a("t3_drain");

    // Overrun with a 4-deep FIFO, then ordered drain
    for (int k = 1; k <= 5; k++) begin
      d = 8'(k * 'h11);
      send(0, d, 0, 0, 1, 0);
      model_a(d, 1, 0);
    end
    check_a("t4_overrun");
    for (int k = 0; k < 4; k++) begin
      pop_a();
      check_a("t4_pop");
    end

    // Full FIFO with pop landing on the push cycle: no overrun, count stays full
    clear_a();
    for (int k = 0; k < DEPTH; k++) begin
      d = 8'($urandom);
      send(0, d, 0, 0, 1, 0);
      model_a(d, 1, 0);
    end
    d = 8'($urandom);
    send(0, d, 0, 0, 1, 1);
    model_a(d, 1, 1);
    check_a("t4_full_pop_push");

    // Randomized frames, stop errors, pops and clears
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send(0, d, 0, 0, ok, 0);
      model_a(d, ok, 0);
      check_a("rand_frame");
      for (int p = $urandom_range(0, 2); p > 0; p--) pop_a();
      if ($urandom_range(0, 7) == 0) clear_a();
      check_a("rand_after");
    end

    // Break: a single framing error, no restart until the line goes high
    clear_a();
    ser_a = 1'b0;
    repeat (160) @(negedge clk);
    m2_a = 1'b1;
    check_a("break_first");
    clear_a();
    repeat (80) @(negedge clk);
    check_a("break_no_second");
    ser_a = 1'b1;
    repeat (8) @(negedge clk);
    while (q_a.size() > 0) pop_a();
    d = 8'($urandom);
    send(0, d, 0, 0, 1, 0);
    model_a(d, 1, 0);
    check_a("break_recover");

    // Even parity on the second instance
    send(1, 8'hA3, 1, 0, 1, 0);
    model_b(8'hA3, 0, 1);
    check_b("t5_good_par");
    send(1, 8'hA3, 1, 1, 1, 0);
    model_b(8'hA3, 1, 1);
    check_b("t5_bad_par");
    clear_b();
    pop_b();
    check_b("t5_clear");
    for (int n = 0; n < 10; n++) begin
      d  = 8'($urandom);
      pb = ((($countones(d) % 2) != 0) ^ ($urandom_range(0, 2) == 0));
      ok = ($urandom_range(0, 5) != 0);
      send(1, d, 1, pb, ok, 0);
      model_b(d, pb, ok);
      check_b("rand_par");
      if ($urandom_range(0, 1) == 1) pop_b();
      if ($urandom_range(0, 3) == 0) clear_b();
    end

    // Reset in the middle of a data bit
    send(0, 8'h77, 0, 0, 1, 0);
    model_a(8'h77, 1, 0);
    ser_a = 1'b0;
    repeat (40) @(negedge clk);
    chk("t6_busy_mid_data", busy_a, 1);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    ser_a = 1'b1;
    rst_b = 1'b1;
    q_a.delete(); q_b.delete();
    m1_a = 0; m2_a = 0; m3_a = 0; m1_b = 0; m2_b = 0; m3_b = 0;
    repeat (2) @(negedge clk);
    check_a("t6_after_reset");
    check_b("t6_after_reset");
    send(0, 8'h3C, 0, 0, 1, 0);
    model_a(8'h3C, 1, 0);
    check_a("t6_0x3c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
